// File: rtl/multicycle_datapath_if.sv
// Controller strobes and shared memory port between the multicycle
// datapath and its surroundings (controller + instruction/data memory).
interface multicycle_datapath_if #(
  parameter int unsigned DW = 32
);
  // Control strobes from the controller
  logic          pcen;
  logic          iord;
  logic          irwrite;
  logic          regdst;
  logic          memtoreg;
  logic          regwrite;
  logic          alusrca;
  logic [1:0]    alusrcb;
  logic [1:0]    pcsrc;
  logic [2:0]    alucontrol;
  // Status back to the controller
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  // Shared memory port
  logic [DW-1:0] adr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  // Controller/memory side
  modport master (
    output pcen, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, readdata,
    input  op, funct, zero, adr, writedata
  );

  // Datapath side
  modport slave (
    input  pcen, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, readdata,
    output op, funct, zero, adr, writedata
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, 32x32 register file
// and ALU, driven cycle by cycle by the controller strobes on the bus.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DW       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_datapath_if.slave  bus,
  input  logic [4:0]            dbg_ra,
  output logic [DW-1:0]         dbg_rd
);

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] rf_q [32];
  logic [DW-1:0] rf_d [32];

  logic [DW-1:0] signimm;
  logic [DW-1:0] srca;
  logic [DW-1:0] srcb;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] jump_target;
  logic [4:0]    wa;
  logic [DW-1:0] wd;
  logic [4:0]    rs;
  logic [4:0]    rt;

  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign signimm     = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign wa          = bus.regdst ? ir_q[15:11] : ir_q[20:16];
  assign wd          = bus.memtoreg ? mdr_q : aluout_q;

  // ALU operand selection and operation
  always_comb begin
    srca = bus.alusrca ? a_q : pc_q;
    case (bus.alusrcb)
      2'b00:   srcb = b_q;
      2'b01:   srcb = DW'(4);
      2'b10:   srcb = signimm;
      default: srcb = {signimm[DW-3:0], 2'b00};
    endcase
    case (bus.alucontrol)
      3'b010:  alu_result = srca + srcb;
      3'b110:  alu_result = srca - srcb;
      3'b000:  alu_result = srca & srcb;
      3'b001:  alu_result = srca | srcb;
      3'b111:  alu_result = ($signed(srca) < $signed(srcb)) ? DW'(1) : '0;
      default: alu_result = '0;
    endcase
  end

  // Next-state values for all datapath registers and the register file
  always_comb begin
    mdr_d    = bus.readdata;
    a_d      = rf_q[rs];
    b_d      = rf_q[rt];
    aluout_d = alu_result;
    ir_d     = bus.irwrite ? bus.readdata : ir_q;
    pc_d     = pc_q;
    if (bus.pcen) begin
      case (bus.pcsrc)
        2'b01:   pc_d = aluout_q;
        2'b10:   pc_d = jump_target;
        default: pc_d = alu_result;
      endcase
    end
    rf_d = rf_q;
    if (bus.regwrite && (wa != 5'd0)) begin
      rf_d[wa] = wd;
    end
  end

  // State update; reset overrides every enable on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      rf_q     <= rf_d;
    end
  end

  assign bus.op        = ir_q[31:26];
  assign bus.funct     = ir_q[5:0];
  assign bus.zero      = (alu_result == '0);
  assign bus.adr       = bus.iord ? aluout_q : pc_q;
  assign bus.writedata = b_q;
  assign dbg_rd        = (dbg_ra == 5'd0) ? '0 : rf_q[dbg_ra];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: the bench plays the
// controller and memory, keeps its own register-file model, and queues
// expected writeback results that are compared when each instruction retires.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  logic [31:0] exp_pc;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
  } wb_t;
  wb_t exp_q [$];

  multicycle_datapath_if #(.DW(32)) bus ();

  multicycle_datapath #(
    .RESET_PC (32'h0000_0000),
    .DW       (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .dbg_ra (dbg_ra),
    .dbg_rd (dbg_rd)
  );

  always #5 clk = ~clk;

  assign bus.readdata = mem[bus.adr[9:2]];

  function automatic logic [31:0] sext(input logic [31:0] instr);
    return {{16{instr[15]}}, instr[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.pcen = 1'b0; bus.iord = 1'b0; bus.irwrite = 1'b0;
    bus.regdst = 1'b0; bus.memtoreg = 1'b0; bus.regwrite = 1'b0;
    bus.alusrca = 1'b0; bus.alusrcb = 2'b00; bus.pcsrc = 2'b00;
    bus.alucontrol = 3'b000;
  endtask

  task automatic check_reg(input string nm, input logic [4:0] r, input logic [31:0] v);
    dbg_ra = r;
    #1;
    checks++;
    if (dbg_rd !== v) begin
      errors++;
      $display("FAIL %s: reg $%0d got %h expected %h", nm, r, dbg_rd, v);
    end
  endtask

  task automatic retire(input string nm);
    wb_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", nm);
    end else begin
      e = exp_q.pop_front();
      check_reg(nm, e.r, e.v);
    end
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] instr);
    mem[exp_pc[9:2]] = instr;
    clear_ctrl();
    bus.irwrite = 1'b1; bus.pcen = 1'b1; bus.alusrca = 1'b0;
    bus.alusrcb = 2'b01; bus.alucontrol = 3'b010; bus.pcsrc = 2'b00;
    tick();
    clear_ctrl();
    #1;
    exp_pc = exp_pc + 32'd4;
    checks++;
    if (bus.op !== instr[31:26]) begin
      errors++;
      $display("FAIL %s op: got %b expected %b", nm, bus.op, instr[31:26]);
    end
    checks++;
    if (bus.adr !== exp_pc) begin
      errors++;
      $display("FAIL %s pc: got %h expected %h", nm, bus.adr, exp_pc);
    end
  endtask

  task automatic do_decode();
    clear_ctrl();
    bus.alusrcb = 2'b11; bus.alucontrol = 3'b010;
    tick();
    clear_ctrl();
  endtask

  task automatic test_reset();
    clear_ctrl();
    dbg_ra = 5'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_pc = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    checks++;
    if (bus.adr !== 32'h0) begin errors++; $display("FAIL reset adr: got %h expected %h", bus.adr, 32'h0); end
    checks++;
    if (bus.op !== 6'd0) begin errors++; $display("FAIL reset op: got %b expected 0", bus.op); end
    checks++;
    if (bus.funct !== 6'd0) begin errors++; $display("FAIL reset funct: got %b expected 0", bus.funct); end
    checks++;
    if (bus.writedata !== 32'h0) begin errors++; $display("FAIL reset writedata: got %h expected 0", bus.writedata); end
    check_reg("reset rf", 5'd2, 32'h0);
  endtask

  task automatic test_addi(input string nm, input logic [31:0] instr);
    logic [4:0]  rs, rt;
    logic [31:0] oldv, newv;
    rs = instr[25:21];
    rt = instr[20:16];
    oldv = model[rt];
    newv = model[rs] + sext(instr);
    if (rt != 5'd0) model[rt] = newv;
    exp_q.push_back('{r: rt, v: model[rt]});
    do_fetch(nm, instr);
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
    tick();
    clear_ctrl();
    bus.regdst = 1'b0; bus.memtoreg = 1'b0; bus.regwrite = 1'b1;
    // write not yet visible before the edge
    check_reg({nm, " pre-write"}, rt, oldv);
    tick();
    clear_ctrl();
    retire(nm);
  endtask

  task automatic test_rtype(input string nm, input logic [31:0] instr);
    logic [4:0]  rs, rt, rd;
    logic [31:0] res;
    logic [2:0]  ctl;
    rs = instr[25:21];
    rt = instr[20:16];
    rd = instr[15:11];
    case (instr[5:0])
      6'h20:   begin ctl = 3'b010; res = model[rs] + model[rt]; end
      6'h22:   begin ctl = 3'b110; res = model[rs] - model[rt]; end
      6'h24:   begin ctl = 3'b000; res = model[rs] & model[rt]; end
      6'h25:   begin ctl = 3'b001; res = model[rs] | model[rt]; end
      default: begin ctl = 3'b111; res = ($signed(model[rs]) < $signed(model[rt])) ? 32'd1 : 32'd0; end
    endcase
    if (rd != 5'd0) model[rd] = res;
    exp_q.push_back('{r: rd, v: model[rd]});
    do_fetch(nm, instr);
    checks++;
    if (bus.funct !== instr[5:0]) begin
      errors++;
      $display("FAIL %s funct: got %b expected %b", nm, bus.funct, instr[5:0]);
    end
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = ctl;
    tick();
    clear_ctrl();
    bus.regdst = 1'b1; bus.regwrite = 1'b1;
    tick();
    clear_ctrl();
    retire(nm);
  endtask

  task automatic test_sw(input logic [31:0] instr);
    logic [31:0] ea, sd;
    ea = model[instr[25:21]] + sext(instr);
    sd = model[instr[20:16]];
    do_fetch("sw", instr);
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
    tick();
    clear_ctrl();
    bus.iord = 1'b1;
    #1;
    checks++;
    if (bus.adr !== ea) begin errors++; $display("FAIL sw adr: got %h expected %h", bus.adr, ea); end
    checks++;
    if (bus.writedata !== sd) begin errors++; $display("FAIL sw writedata: got %h expected %h", bus.writedata, sd); end
    tick();
    clear_ctrl();
  endtask

  task automatic test_lw(input logic [31:0] instr);
    logic [31:0] ea;
    logic [4:0]  rt;
    ea = model[instr[25:21]] + sext(instr);
    rt = instr[20:16];
    if (rt != 5'd0) model[rt] = mem[ea[9:2]];
    exp_q.push_back('{r: rt, v: model[rt]});
    do_fetch("lw", instr);
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
    tick();
    clear_ctrl();
    bus.iord = 1'b1;
    tick();
    clear_ctrl();
    bus.regdst = 1'b0; bus.memtoreg = 1'b1; bus.regwrite = 1'b1;
    tick();
    clear_ctrl();
    retire("lw");
  endtask

  task automatic test_beq(input string nm, input logic [31:0] instr);
    logic ez;
    ez = (model[instr[25:21]] == model[instr[20:16]]);
    do_fetch(nm, instr);
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b00; bus.alucontrol = 3'b110;
    #1;
    checks++;
    if (bus.zero !== ez) begin errors++; $display("FAIL %s zero: got %b expected %b", nm, bus.zero, ez); end
    tick();
    clear_ctrl();
  endtask

  task automatic test_jump(input logic [31:0] instr);
    do_fetch("j", instr);
    do_decode();
    bus.pcen = 1'b1; bus.pcsrc = 2'b10;
    tick();
    clear_ctrl();
    exp_pc = {exp_pc[31:28], instr[25:0], 2'b00};
    #1;
    checks++;
    if (bus.adr !== exp_pc) begin errors++; $display("FAIL jump adr: got %h expected %h", bus.adr, exp_pc); end
  endtask

  task automatic test_reset_mid();
    do_fetch("mid", 32'h2005_0001);
    do_decode();
    bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
    tick();
    clear_ctrl();
    bus.regwrite = 1'b1; bus.pcen = 1'b1; bus.alusrcb = 2'b01; bus.alucontrol = 3'b010;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_ctrl();
    exp_pc = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    checks++;
    if (bus.adr !== exp_pc) begin errors++; $display("FAIL mid-reset pc: got %h expected %h", bus.adr, exp_pc); end
    checks++;
    if (bus.op !== 6'd0) begin errors++; $display("FAIL mid-reset ir: got %b expected 0", bus.op); end
    checks++;
    if (bus.writedata !== 32'h0) begin errors++; $display("FAIL mid-reset writedata: got %h expected 0", bus.writedata); end
    check_reg("mid-reset target", 5'd5, 32'h0);
    check_reg("mid-reset rf", 5'd2, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[20] = 32'hDEAD_BEEF;
    reset = 1'b0;
    dbg_ra = 5'd0;
    clear_ctrl();
    test_reset();
    test_addi("addi $2", 32'h2002_0005);
    test_addi("addi $3", 32'h2003_000c);
    test_addi("addi $7", 32'h2007_0003);
    test_rtype("or", 32'h00e2_2025);
    test_rtype("sub", 32'h00e2_3822);
    test_addi("addi $7=7", 32'h2007_0007);
    test_sw(32'hac67_0044);
    test_lw(32'h8c02_0050);
    test_beq("beq equal", 32'h1063_0000);
    test_beq("beq unequal", 32'h1043_0000);
    test_addi("addi $0", 32'h2000_0009);
    test_jump(32'h0800_0010);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Execution end of the multicycle MIPS core: receives the per-cycle control strobes from `controller` and returns `op`, `funct` and `zero`.
- Holds the PC, the non-architectural registers (IR, MDR, A, B, ALUOut), a 32x32 register file and the ALU.
- Drives one shared instruction/data memory port.
- Top level instantiates `controller` + `multicycle_datapath` + memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pcen  in  1  PC write enable (controller already ORs in the branch-taken term).
- iord  in  1  0: adr=PC; 1: adr=ALUOut.
- irwrite  in  1  load IR from readdata.
- regdst  in  1  0: write reg = instr[20:16]; 1: instr[15:11].
- memtoreg  in  1  0: write data = ALUOut; 1: MDR.
- regwrite  in  1  register-file write enable.
- alusrca  in  1  0: srcA=PC; 1: srcA=A.
- alusrcb  in  2  00 B, 01 constant 4, 10 signimm, 11 signimm<<2.
- pcsrc  in  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],instr[25:0],2'b00}, 11 reserved (treat as 00).
- alucontrol  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt; others produce 0.
- readdata  in  32  memory read data, combinational from adr.
- op  out  6  IR[31:26].
- funct  out  6  IR[5:0].
- zero  out  1  ALU result == 0, combinational.
- adr  out  32  memory address.
- writedata  out  32  B register (store data).
- dbg_ra  in  5  debug register-file read address.
- dbg_rd  out  32  debug register-file read data, combinational; $0 reads 0.

Behaviour:
- Reset (synchronous, reset=1 at the edge):
  - PC=RESET_PC; IR, MDR, A, B, ALUOut = 0.
  - Every register-file entry = 0.
  - Outputs after reset: op=0, funct=0, adr=RESET_PC (iord=0), writedata=0.
- Register updates every clock when reset=0:
  - MDR<=readdata.
  - A<=RF[IR[25:21]]; B<=RF[IR[20:16]].
  - ALUOut<=ALU result.
- Gated register updates:
  - IR<=readdata only when irwrite=1.
  - PC<=pcsrc mux only when pcen=1.
  - RF[wa]<=wd only when regwrite=1.
- Register file:
  - Two combinational read ports plus the debug port.
  - `$0` is hardwired to 0 and ignores writes.
  - Write-then-read in the same cycle: the read returns the old value; the new value is visible the next cycle.
- signimm = sign-extend IR[15:0] to 32 bits.
- ALU:
  - 32-bit wrap-around add/sub; no overflow flag.
  - slt is a signed compare giving 32'h1 or 32'h0.
  - zero is computed on the current-cycle ALU result.
- Latency: IR and PC change one cycle after their enables; op/funct follow IR in the same cycle.
- Simultaneous irwrite and pcen (fetch cycle): PC and IR both update on the same edge from pre-edge values.
  - adr uses the old PC, so the instruction at the old PC is latched.
- Reset asserted mid-instruction overrides all enables on that edge, including regwrite and pcen.
- The block performs no memory write itself; the memory write strobe comes from the controller's memwrite.

Test Plan:
- Reset high 2 cycles, then low -> adr=0, op=0, funct=0, dbg_rd($2)=0, writedata=0.
- Fetch of 0x20020005 with irwrite=1, pcen=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00 -> next cycle op=6'b001000, PC/adr=4.
  - Then decode, execute (alusrca=1, alusrcb=10), writeback (regdst=0, memtoreg=0, regwrite=1) -> dbg_rd($2)=5.
  - Repeat with 0x2003000c -> $3=12.
- R-type sequence: $7=3 preloaded via addi, then 0x00e22025 (or, regdst=1, alucontrol=001) -> $4=7 and funct=6'b100101.
  - Then 0x00e23822 (sub) -> $7=0xFFFFFFFE.
- sw 0xac670044 with $3=12, $7=7 -> on the memory cycle (iord=1) adr=0x50, writedata=7.
  - lw 0x8c020050 with readdata=0xDEADBEEF, memtoreg=1 -> $2=0xDEADBEEF.
- beq compare with srcA=A=B, alucontrol=110 -> zero=1 that cycle; unequal operands -> zero=0.
  - Write to $0 with regwrite=1 -> dbg_rd($0)=0.
- Reset asserted while regwrite=1 and pcen=1 -> PC=RESET_PC, target register stays 0, IR=0.
